tt_um_axi4_lite: RTL and testbench

- TinyTapeout-style top containing an AXI4-Lite master FSM and an AXI4-Lite slave register file, both internal.
- Pin commands start one single-beat write or read. The master runs the full AXI4-Lite handshake to the slave and reports completion on a done pin.
- Read data is driven on the bidirectional bus.

---
 rtl/axi4lite_pkg.sv | 22 ++
 rtl/axi4lite_if.sv | 35 +++
 rtl/axi4lite_slave.sv | 65 ++++++
 rtl/tt_um_axi4_lite.sv | 131 +++++++++++++
 tb/tb_tt_um_axi4_lite.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the tt_um_axi4_lite AXI4-Lite master/slave pair.
// The optional AXI4LITE_STATUS_EN build adds status bits on uo_out.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // ui_in field positions; read and write address fields overlap on bit 2
    localparam int unsigned PIN_START_WRITE = 0;
    localparam int unsigned PIN_WADDR_LSB   = 1;
    localparam int unsigned PIN_RADDR_LSB   = 2;
    localparam int unsigned PIN_START_READ  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWReq,
        StWResp,
        StRReq,
        StRResp
    } master_state_e;

endpackage

// File: rtl/axi4lite_if.sv
// Single-beat AXI4-Lite bus between the internal master FSM and the register-file slave.
interface axi4lite_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4lite_slave.sv
// AXI4-Lite register-file slave: 2**ADDR_WIDTH registers, always OKAY responses.
module axi4lite_slave
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    axi4lite_if.slave bus
);

    localparam int unsigned NumRegs   = 2 ** ADDR_WIDTH;
    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_hs;
    logic                  rd_hs;

    // AW and W are only taken together, and only while no response is pending
    assign bus.awready = !bvalid_q;
    assign bus.wready  = !bvalid_q;
    assign bus.arready = !rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = OKAY;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = OKAY;

    assign wr_hs = bus.awvalid && bus.wvalid && !bvalid_q;
    assign rd_hs = bus.arvalid && !rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_hs) begin
                for (int b = 0; b < StrbWidth; b++) begin
                    if (bus.wstrb[b]) begin
                        regs_q[bus.awaddr][8*b +: 8] <= bus.wdata[8*b +: 8];
                    end
                end
                bvalid_q <= 1'b1;
            end else if (bvalid_q && bus.bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_hs) begin
                rdata_q  <= regs_q[bus.araddr];
                rvalid_q <= 1'b1;
            end else if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tt_um_axi4_lite.sv
// TinyTapeout top: pin-driven AXI4-Lite master FSM talking to an internal register-file slave.
// Define AXI4LITE_STATUS_EN to expose busy, last response and rd_valid on uo_out[4:1].
module tt_um_axi4_lite
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    axi4lite_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi4lite_slave #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slave (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    master_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  done_q;
    logic                  rd_valid_q;
    logic                  start_write;
    logic                  start_read;

    // Starts only count in IDLE; write wins when both are high
    assign start_write = ena && ui_in[PIN_START_WRITE];
    assign start_read  = ena && ui_in[PIN_START_READ] && !ui_in[PIN_START_WRITE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_write) begin
                    state_d = StWReq;
                end else if (start_read) begin
                    state_d = StRReq;
                end
            end
            StWReq:  if (bus.awready && bus.wready) state_d = StWResp;
            StWResp: if (bus.bvalid) state_d = StIdle;
            StRReq:  if (bus.arready) state_d = StRResp;
            StRResp: if (bus.rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.awvalid = (state_q == StWReq);
        bus.wvalid  = (state_q == StWReq);
        bus.bready  = (state_q == StWResp);
        bus.arvalid = (state_q == StRReq);
        bus.rready  = (state_q == StRResp);
        bus.awaddr  = addr_q;
        bus.araddr  = addr_q;
        bus.wdata   = wdata_q;
        bus.wstrb   = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start_write) begin
                addr_q     <= ui_in[PIN_WADDR_LSB +: ADDR_WIDTH];
                wdata_q    <= uio_in;
                done_q     <= 1'b0;
                rd_valid_q <= 1'b0;
            end else if (state_q == StIdle && start_read) begin
                addr_q <= ui_in[PIN_RADDR_LSB +: ADDR_WIDTH];
                done_q <= 1'b0;
            end else if (state_q == StWResp && bus.bvalid) begin
                done_q <= 1'b1;
            end else if (state_q == StRResp && bus.rvalid) begin
                rd_data_q  <= bus.rdata;
                rd_valid_q <= 1'b1;
                done_q     <= 1'b1;
            end
        end
    end

    assign uio_out = rd_data_q;
    assign uio_oe  = {8{rd_valid_q}};

    logic unused_pins;
    assign unused_pins = ^ui_in[7:5];

`ifdef AXI4LITE_STATUS_EN
    logic [1:0] last_resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_resp_q <= OKAY;
        end else if (state_q == StWResp && bus.bvalid) begin
            last_resp_q <= bus.bresp;
        end else if (state_q == StRResp && bus.rvalid) begin
            last_resp_q <= bus.rresp;
        end
    end

    assign uo_out = {3'b000, rd_valid_q, last_resp_q, (state_q != StIdle), done_q};
`else
    logic unused_resp;
    assign unused_resp = ^{bus.bresp, bus.rresp};

    assign uo_out = {7'b0000000, done_q};
`endif

endmodule

// File: tb/tb_tt_um_axi4_lite.sv
// Randomized self-checking bench for tt_um_axi4_lite against a register-array reference model.
module tb_tt_um_axi4_lite;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int checks = 0;
    int errors = 0;
    int wr_hs_cnt = 0;
    int rd_hs_cnt = 0;

    // Reference model
    logic [7:0] mem_m [4];
    logic [7:0] last_rd_m = 8'h00;
    logic       rd_valid_m = 1'b0;
    logic       done_m = 1'b0;

    always #5 clk = ~clk;

    tt_um_axi4_lite dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    // Passive copy of the internal bus for handshake counting
    axi4lite_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) mon ();
    assign mon.awvalid = dut.bus.awvalid;
    assign mon.awready = dut.bus.awready;
    assign mon.awaddr  = dut.bus.awaddr;
    assign mon.wvalid  = dut.bus.wvalid;
    assign mon.wready  = dut.bus.wready;
    assign mon.wdata   = dut.bus.wdata;
    assign mon.wstrb   = dut.bus.wstrb;
    assign mon.bvalid  = dut.bus.bvalid;
    assign mon.bready  = dut.bus.bready;
    assign mon.bresp   = dut.bus.bresp;
    assign mon.arvalid = dut.bus.arvalid;
    assign mon.arready = dut.bus.arready;
    assign mon.araddr  = dut.bus.araddr;
    assign mon.rvalid  = dut.bus.rvalid;
    assign mon.rready  = dut.bus.rready;
    assign mon.rdata   = dut.bus.rdata;
    assign mon.rresp   = dut.bus.rresp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mon.awvalid && mon.awready && mon.wvalid && mon.wready) wr_hs_cnt++;
            if (mon.arvalid && mon.arready) rd_hs_cnt++;
            if (mon.bvalid && mon.bready) begin
                checks++;
                if (mon.bresp !== 2'b00) begin
                    errors++;
                    $display("FAIL bresp: got %b want 00", mon.bresp);
                end
            end
        end
    end

    task automatic wait_done(output int lat);
        int c = 0;
        while (uo_out[0] !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        lat = (uo_out[0] === 1'b1) ? c : -1;
    endtask

    // Pulse one start for a single edge; lat counts edges after the start edge until done
    task automatic do_write(input logic [1:0] addr, input logic [7:0] data, input logic also_read,
                            output int lat, output logic done0);
        @(negedge clk);
        ui_in = 8'h01;
        ui_in[2:1] = addr;
        ui_in[4] = also_read;
        uio_in = data;
        @(negedge clk);
        ui_in = 8'h00;
        done0 = uo_out[0];
        mem_m[addr] = data;
        rd_valid_m = 1'b0;
        done_m = 1'b1;
        wait_done(lat);
    endtask

    task automatic do_read(input logic [1:0] addr, output int lat, output logic done0);
        @(negedge clk);
        ui_in = 8'h10;
        ui_in[3:2] = addr;
        @(negedge clk);
        ui_in = 8'h00;
        done0 = uo_out[0];
        last_rd_m = mem_m[addr];
        rd_valid_m = 1'b1;
        done_m = 1'b1;
        wait_done(lat);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
        last_rd_m = 8'h00;
        rd_valid_m = 1'b0;
        done_m = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        logic d0;
        logic [1:0] a;
        model_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got uo=%h uio_out=%h oe=%h want 00/00/00",
                     uo_out, uio_out, uio_oe);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = 2'($urandom_range(0, 3));
        do_read(a, lat, d0);
        checks++;
        if (lat != 2 || uio_out !== mem_m[a] || uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL reset_read: addr %0d lat %0d data %h oe %h want lat 2 data %h oe ff",
                     a, lat, uio_out, uio_oe, mem_m[a]);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic d0;
        do_write(2'd2, 8'h04, 1'b0, lat, d0);
        checks++;
        if (lat != 2 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: lat %0d done_at_start %b want 2/0", lat, d0);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL write_clears_oe: got %h want 00", uio_oe);
        end
        do_read(2'd2, lat, d0);
        checks++;
        if (lat != 2 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: lat %0d done_at_start %b want 2/0", lat, d0);
        end
        checks++;
        if (uio_out !== 8'h04 || uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL read_data: got %h oe %h want 04 oe ff", uio_out, uio_oe);
        end
    endtask

    task automatic test_all_addresses();
        int lat;
        logic d0;
        logic [7:0] pat;
        for (int i = 0; i < 4; i++) begin
            pat = 8'(8'h11 * (i + 1));
            do_write(2'(i), pat, 1'b0, lat, d0);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), lat, d0);
            pat = 8'(8'h11 * (i + 1));
            checks++;
            if (uio_out !== pat || lat != 2) begin
                errors++;
                $display("FAIL all_addr[%0d]: got %h lat %0d want %h lat 2", i, uio_out, lat, pat);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic d0;
        logic [1:0] a;
        for (int n = 0; n < 30; n++) begin
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), 1'b0, lat, d0);
            else do_read(a, lat, d0);
            checks++;
            if (lat != 2 || uo_out[0] !== done_m || uio_out !== last_rd_m ||
                uio_oe !== {8{rd_valid_m}}) begin
                errors++;
                $display("FAIL random[%0d]: lat %0d done %b data %h oe %h want 2 %b %h %h", n, lat,
                         uo_out[0], uio_out, uio_oe, done_m, last_rd_m, {8{rd_valid_m}});
            end
        end
    endtask

    task automatic test_simultaneous();
        int lat, w0, r0;
        logic d0;
        logic [7:0] data;
        do_read(2'd1, lat, d0);
        w0 = wr_hs_cnt;
        r0 = rd_hs_cnt;
        data = 8'($urandom);
        do_write(2'd3, data, 1'b1, lat, d0);
        checks++;
        if (wr_hs_cnt - w0 != 1 || rd_hs_cnt - r0 != 0) begin
            errors++;
            $display("FAIL simul_count: writes %0d reads %0d want 1/0",
                     wr_hs_cnt - w0, rd_hs_cnt - r0);
        end
        checks++;
        if (uio_out !== last_rd_m || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL simul_outputs: data %h oe %h want %h 00", uio_out, uio_oe, last_rd_m);
        end
        do_read(2'd3, lat, d0);
        checks++;
        if (uio_out !== data) begin
            errors++;
            $display("FAIL simul_readback: got %h want %h", uio_out, data);
        end
    endtask

    task automatic test_busy_and_ena();
        int lat, w0, r0;
        logic [7:0] keep;
        w0 = wr_hs_cnt;
        r0 = rd_hs_cnt;
        @(negedge clk);
        ui_in = 8'h03;
        uio_in = 8'h9C;
        @(negedge clk);
        ui_in = 8'h18;
        `ifdef AXI4LITE_STATUS_EN
        checks++;
        if (uo_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL busy_flag: got %b want 1", uo_out[1]);
        end
        `endif
        @(negedge clk);
        ui_in = 8'h00;
        mem_m[1] = 8'h9C;
        rd_valid_m = 1'b0;
        done_m = 1'b1;
        wait_done(lat);
        repeat (2) @(negedge clk);
        checks++;
        if (lat != 1 || wr_hs_cnt - w0 != 1 || rd_hs_cnt - r0 != 0) begin
            errors++;
            $display("FAIL busy_ignore: lat %0d writes %0d reads %0d want 1/1/0", lat,
                     wr_hs_cnt - w0, rd_hs_cnt - r0);
        end
        w0 = wr_hs_cnt;
        r0 = rd_hs_cnt;
        keep = mem_m[0];
        ena = 1'b0;
        ui_in = 8'h11;
        uio_in = ~keep;
        repeat (4) @(negedge clk);
        ui_in = 8'h00;
        checks++;
        if (uo_out[0] !== done_m || wr_hs_cnt != w0 || rd_hs_cnt != r0) begin
            errors++;
            $display("FAIL ena_block: done %b writes %0d reads %0d want %b/0/0", uo_out[0],
                     wr_hs_cnt - w0, rd_hs_cnt - r0, done_m);
        end
        ena = 1'b1;
        do_read(2'd0, lat, keep[0]);
        checks++;
        if (uio_out !== mem_m[0]) begin
            errors++;
            $display("FAIL ena_no_write: got %h want %h", uio_out, mem_m[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic d0;
        @(negedge clk);
        ui_in = 8'h07;
        uio_in = 8'hA5;
        @(negedge clk);
        ui_in = 8'h00;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: uo %h oe %h data %h want 00", uo_out, uio_oe,
                     uio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_read(2'd3, lat, d0);
        checks++;
        if (uio_out !== 8'h00 || lat != 2) begin
            errors++;
            $display("FAIL reset_mid_reg: got %h lat %0d want 00 lat 2", uio_out, lat);
        end
        `ifdef AXI4LITE_STATUS_EN
        checks++;
        if (uo_out[4:1] !== 4'b1000) begin
            errors++;
            $display("FAIL status_bits: got %b want 1000", uo_out[4:1]);
        end
        `else
        checks++;
        if (uo_out[7:1] !== 7'd0) begin
            errors++;
            $display("FAIL status_absent: got %b want 0", uo_out[7:1]);
        end
        `endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_addresses();
        test_random();
        test_simultaneous();
        test_busy_and_ena();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
